// File: rtl/multiplier_8bit_seq.sv
// multiplier_8bit_seq: sequential shift-add reconstruction p = q*b + r.
// Rebuilds a divider_8bit dividend from its quotient, divisor and remainder.
// One divisor bit is consumed per clock. Control uses a start/busy/done handshake.
// Optional feature macro: REM_CHECK_EN. When it is defined, a remainder-range
// flag (r >= b) is latched on accept and shown on rem_err during done.
module multiplier_8bit_seq #(
    parameter int unsigned QW = 8,
    parameter int unsigned BW = 4,
    parameter int unsigned RW = 5,
    parameter int unsigned PW = QW + BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [QW-1:0] q,
    input  logic [BW-1:0] b,
    input  logic [RW-1:0] r,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] p,
    output logic          rem_err
);

    localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] qsh_q, qsh_d;
    logic [BW-1:0] bsh_q, bsh_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and datapath registers; rst overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            qsh_q   <= '0;
            bsh_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            qsh_q   <= qsh_d;
            bsh_q   <= bsh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: latch operands on accept, then do one shift-add step per MUL cycle.
    always_comb begin
        state_d = state_q;
        qsh_d   = qsh_q;
        bsh_d   = bsh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MUL;
                    qsh_d   = PW'(q);
                    bsh_d   = b;
                    acc_d   = PW'(r);
                    cnt_d   = '0;
                end
            end
            MUL: begin
                if (bsh_q[0]) begin
                    acc_d = acc_q + qsh_q;
                end
                qsh_d = qsh_q << 1;
                bsh_d = bsh_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BW - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == MUL);
    assign done = (state_q == DONE);
    assign p    = acc_q;

`ifdef REM_CHECK_EN
    localparam int unsigned MW = (RW > BW) ? RW : BW;

    logic rem_lat_q, rem_lat_d;

    // Remainder-range flag captured on accept, held through the operation.
    always_comb begin
        rem_lat_d = rem_lat_q;
        if ((state_q == IDLE) && start) begin
            rem_lat_d = (MW'(r) >= MW'(b));
        end
    end

    // Remainder-range flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_lat_q <= 1'b0;
        end else begin
            rem_lat_q <= rem_lat_d;
        end
    end

    assign rem_err = done & rem_lat_q;
`else
    assign rem_err = 1'b0;
`endif

endmodule
